mips_multicycle_core: RTL and testbench

Multicycle MIPS core: one shared unified-memory port with a request/ready handshake, and an FSM that sequences fetch, decode, execute, memory and writeback over several cycles per instruction. It is the next generation of the single-cycle MIPS top. It reuses the ALU, register-file and sign-extend building blocks. The instruction and data memories are merged into one external memory that may insert wait states.

---
 rtl/mips_multicycle_core.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// ---------------------------------------------------------------------------
// mips_multicycle_core
//
// Multicycle MIPS core that shares one unified memory port between instruction
// fetch and data access. An FSM steps each instruction through fetch, decode,
// execute, memory and writeback. Any number of memory wait states may be
// inserted through the MemReq/MemReady handshake.
//
// Parameters:
//   PC_RESET    program counter value loaded on reset
//   ADDR_WIDTH  width of MemAddr (low bits of the byte address)
//
// Ports:
//   CLOCK     in   sole clock, rising edge
//   RESET     in   synchronous active-high reset
//   MemReq    out  memory access request
//   MemWE     out  1 = write, 0 = read (meaningful only with MemReq)
//   MemAddr   out  word-aligned byte address
//   MemWD     out  store data
//   MemRD     in   load / fetch data, valid while MemReady=1
//   MemReady  in   access completes on an edge with MemReq=1 and MemReady=1
//   PC        out  current program counter
//   Halted    out  core stopped on an unsupported instruction
//   Retired   out  completed-instruction counter (wraps)
//
// Configuration macro:
//   MIPS_MC_BNE_EN  when defined, opcode 0x05 (bne) is decoded as a branch
//                   with an inverted compare; otherwise it halts the core.
// ---------------------------------------------------------------------------
module mips_multicycle_core #(
   parameter logic [31:0] PC_RESET   = 32'h0000_0000,
   parameter int          ADDR_WIDTH = 32
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   output logic                  MemReq,
   output logic                  MemWE,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [31:0]           MemWD,
   input  logic [31:0]           MemRD,
   input  logic                  MemReady,
   output logic [31:0]           PC,
   output logic                  Halted,
   output logic [31:0]           Retired
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MIPS_MC_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'h05;
`endif
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_ADDIEX,
      S_ADDIWB,
      S_BRANCH,
      S_JUMP,
      S_HALT
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] mdr_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] alu_out_q;
   logic [31:0] retired_q;
   logic [31:0] regs [32];

   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [31:0] sign_imm;
   logic        funct_ok;
   logic [31:0] rf_a;
   logic [31:0] rf_b;
   logic [31:0] alu_result;
   logic        branch_taken;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr_full;
   logic [31:0] mem_wd;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        retire;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign sign_imm = {{16{ir_q[15]}}, ir_q[15:0]};

   assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);

   assign rf_a = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign rf_b = (rt == 5'd0) ? 32'd0 : regs[rt];

   // R-type ALU operating on the A/B operand registers latched in DECODE.
   // slt is a signed compare; unsupported functs never reach EXEC.
   always_comb begin
      alu_result = 32'd0;
      case (funct)
         FN_ADD:  alu_result = a_q + b_q;
         FN_SUB:  alu_result = a_q - b_q;
         FN_AND:  alu_result = a_q & b_q;
         FN_OR:   alu_result = a_q | b_q;
         FN_SLT:  alu_result = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
         default: alu_result = 32'd0;
      endcase
   end

`ifdef MIPS_MC_BNE_EN
   assign branch_taken = (opcode == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
   assign branch_taken = (a_q == b_q);
`endif

   // State register. RESET abandons whatever the FSM was doing, including a
   // memory access that is still waiting for MemReady.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state <= S_FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode. The memory request, register-file write
   // and retire strobe all come from here; memory states only advance when
   // MemReady is seen, which holds the request stable through wait states.
   always_comb begin
      next_state    = state;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_full = 32'd0;
      mem_wd        = 32'd0;
      rf_we         = 1'b0;
      rf_waddr      = 5'd0;
      rf_wdata      = 32'd0;
      retire        = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req       = 1'b1;
            mem_addr_full = pc_q;
            if (MemReady) begin
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE:     next_state = funct_ok ? S_EXEC : S_HALT;
               OP_BEQ:       next_state = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
               OP_BNE:       next_state = S_BRANCH;
`endif
               OP_ADDI:      next_state = S_ADDIEX;
               OP_J:         next_state = S_JUMP;
               default:      next_state = S_HALT;
            endcase
         end
         S_MEMADR: begin
            next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req       = 1'b1;
            mem_addr_full = alu_out_q;
            if (MemReady) begin
               next_state = S_MEMWB;
            end
         end
         S_MEMWB: begin
            rf_we      = 1'b1;
            rf_waddr   = rt;
            rf_wdata   = mdr_q;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_MEMWR: begin
            mem_req       = 1'b1;
            mem_we        = 1'b1;
            mem_addr_full = alu_out_q;
            mem_wd        = b_q;
            if (MemReady) begin
               retire     = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_EXEC: begin
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            rf_we      = 1'b1;
            rf_waddr   = rd;
            rf_wdata   = alu_out_q;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_ADDIEX: begin
            next_state = S_ADDIWB;
         end
         S_ADDIWB: begin
            rf_we      = 1'b1;
            rf_waddr   = rt;
            rf_wdata   = alu_out_q;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH, S_JUMP: begin
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_HALT: begin
            next_state = S_HALT;
         end
         default: begin
            next_state = S_FETCH;
         end
      endcase
   end

   // Datapath registers: PC, IR, MDR, A, B, ALUOut and the retire counter.
   // DECODE always precomputes the branch target into ALUOut so BRANCH only
   // has to pick it up.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         pc_q      <= PC_RESET;
         ir_q      <= 32'd0;
         mdr_q     <= 32'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         alu_out_q <= 32'd0;
         retired_q <= 32'd0;
      end else begin
         case (state)
            S_FETCH: begin
               if (MemReady) begin
                  ir_q <= MemRD;
                  pc_q <= pc_q + 32'd4;
               end
            end
            S_DECODE: begin
               a_q       <= rf_a;
               b_q       <= rf_b;
               alu_out_q <= pc_q + (sign_imm << 2);
            end
            S_MEMADR, S_ADDIEX: begin
               alu_out_q <= a_q + sign_imm;
            end
            S_MEMRD: begin
               if (MemReady) begin
                  mdr_q <= MemRD;
               end
            end
            S_EXEC: begin
               alu_out_q <= alu_result;
            end
            S_BRANCH: begin
               if (branch_taken) begin
                  pc_q <= alu_out_q;
               end
            end
            S_JUMP: begin
               pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            end
            default: begin
            end
         endcase
         if (retire) begin
            retired_q <= retired_q + 32'd1;
         end
      end
   end

   // Register file: written on the writeback edge, cleared by RESET.
   // Writes to $0 are dropped so it always reads back as zero.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (rf_we && (rf_waddr != 5'd0)) begin
         regs[rf_waddr] <= rf_wdata;
      end
   end

   // The memory port is forced idle while RESET is high so that an access in
   // flight is dropped immediately.
   assign MemReq  = mem_req & ~RESET;
   assign MemWE   = mem_we & ~RESET;
   assign MemAddr = RESET ? '0 : mem_addr_full[ADDR_WIDTH-1:0];
   assign MemWD   = RESET ? 32'd0 : mem_wd;
   assign PC      = pc_q;
   assign Halted  = (state == S_HALT);
   assign Retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_core
//
// Self-checking bench for mips_multicycle_core. A behavioural unified memory
// answers the core's requests with a programmable number of wait states.
// Expected stores are queued before each program runs and popped as the core
// writes. A table of ALU vectors is run as small programs, followed by
// hand-written sequences for load/store waits, branches, jump, halt, bne and
// reset during a pending load.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_core;

   localparam logic [31:0] BASE      = 32'h1000_0000;
   localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        MemReq;
   logic        MemWE;
   logic [31:0] MemAddr;
   logic [31:0] MemWD;
   logic [31:0] MemRD;
   logic        MemReady;
   logic [31:0] PC;
   logic        Halted;
   logic [31:0] Retired;

   mips_multicycle_core #(
      .PC_RESET   (BASE),
      .ADDR_WIDTH (32)
   ) dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .MemReq   (MemReq),
      .MemWE    (MemWE),
      .MemAddr  (MemAddr),
      .MemWD    (MemWD),
      .MemRD    (MemRD),
      .MemReady (MemReady),
      .PC       (PC),
      .Halted   (Halted),
      .Retired  (Retired)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      string       name;
      logic [15:0] imm_a;
      logic [15:0] imm_b;
      logic [5:0]  funct;
      int          waits;
      logic [31:0] expected;
   } alu_vec_t;

   logic [31:0] mem [0:1023];
   wr_t         exp_q [$];
   int          wait_states = 0;
   int          n_compared = 0;
   int          n_mismatched = 0;

   // Compare one value and report a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge CLOCK);
      #1;
   endtask

   // Hold the core in reset, clear memory and the store scoreboard.
   task automatic begin_test();
      RESET = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 32'd0;
      end
   endtask

   // Run reset for two edges with the chosen wait states, then release it.
   task automatic applyStimulus(input int waits);
      wait_states = waits;
      step(2);
      RESET = 1'b0;
      #1;
   endtask

   task automatic wait_for_halt(input int bound, output int cycles);
      cycles = 0;
      while (Halted !== 1'b1 && cycles < bound) begin
         step(1);
         cycles++;
      end
      checkOutput("halt_reached", {31'd0, Halted}, 32'd1);
   endtask

   // Behavioural memory. Decides MemReady on the falling edge, checks that a
   // waiting request stays stable, and scoreboards every completed store.
   initial begin
      int          wait_cnt;
      bit          waiting;
      logic [31:0] snap_addr;
      logic [31:0] snap_wd;
      logic        snap_we;
      wr_t         e;
      MemReady = 1'b0;
      MemRD    = 32'd0;
      wait_cnt = 0;
      waiting  = 1'b0;
      forever begin
         @(negedge CLOCK);
         if (MemReq === 1'b1) begin
            if (waiting) begin
               checkOutput("stable_addr", MemAddr, snap_addr);
               checkOutput("stable_we", {31'd0, MemWE}, {31'd0, snap_we});
               checkOutput("stable_wd", MemWD, snap_wd);
            end
            if (wait_cnt < wait_states) begin
               wait_cnt++;
               MemReady  = 1'b0;
               MemRD     = $urandom;
               waiting   = 1'b1;
               snap_addr = MemAddr;
               snap_we   = MemWE;
               snap_wd   = MemWD;
            end else begin
               MemReady = 1'b1;
               wait_cnt = 0;
               waiting  = 1'b0;
               if (MemWE === 1'b1) begin
                  mem[MemAddr[11:2]] = MemWD;
                  MemRD = $urandom;
                  if (exp_q.size() == 0) begin
                     n_compared++;
                     n_mismatched++;
                     $display("[TB] FAIL unexpected_store: got %h @ %h, expected none", MemWD, MemAddr);
                  end else begin
                     e = exp_q.pop_front();
                     checkOutput("store_addr", MemAddr, e.addr);
                     checkOutput("store_data", MemWD, e.data);
                  end
               end else begin
                  MemRD = mem[MemAddr[11:2]];
               end
            end
         end else begin
            MemReady = 1'($urandom_range(0, 1));
            MemRD    = $urandom;
            wait_cnt = 0;
            waiting  = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      alu_vec_t vecs [10];
      int       cyc;

      vecs[0] = '{"add",       16'd5,      16'd7,      6'h20, 0, 32'h0000_000C};
      vecs[1] = '{"sub_neg",   16'd5,      16'd7,      6'h22, 1, 32'hFFFF_FFFE};
      vecs[2] = '{"and",       16'h00FF,   16'h0F0F,   6'h24, 0, 32'h0000_000F};
      vecs[3] = '{"or",        16'h00FF,   16'h0F0F,   6'h25, 2, 32'h0000_0FFF};
      vecs[4] = '{"slt_true",  16'hFFFD,   16'd5,      6'h2A, 0, 32'd1};
      vecs[5] = '{"slt_false", 16'd5,      16'hFFFD,   6'h2A, 1, 32'd0};
      vecs[6] = '{"slt_equal", 16'd7,      16'd7,      6'h2A, 0, 32'd0};
      vecs[7] = '{"sub_min",   16'h8000,   16'd1,      6'h22, 0, 32'hFFFF_7FFF};
      vecs[8] = '{"add_max",   16'h7FFF,   16'h7FFF,   6'h20, 2, 32'h0000_FFFE};
      vecs[9] = '{"add_wrap0", 16'hFFFF,   16'd1,      6'h20, 0, 32'd0};

      // Values held during reset.
      step(3);
      checkOutput("rst_memreq", {31'd0, MemReq}, 32'd0);
      checkOutput("rst_memwe", {31'd0, MemWE}, 32'd0);
      checkOutput("rst_memaddr", MemAddr, 32'd0);
      checkOutput("rst_memwd", MemWD, 32'd0);
      checkOutput("rst_pc", PC, BASE);
      checkOutput("rst_retired", Retired, 32'd0);
      checkOutput("rst_halted", {31'd0, Halted}, 32'd0);

      // addi/addi/add then store $3, zero wait states.
      begin_test();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
      mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      mem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
      mem[4] = HALT_WORD;
      exp_q.push_back('{32'h40, 32'd12});
      applyStimulus(0);
      checkOutput("first_memreq", {31'd0, MemReq}, 32'd1);
      checkOutput("first_memaddr", MemAddr, BASE);
      checkOutput("first_memwe", {31'd0, MemWE}, 32'd0);
      step(12);
      checkOutput("seq3_pc", PC, BASE + 32'd12);
      checkOutput("seq3_retired", Retired, 32'd3);
      wait_for_halt(50, cyc);
      checkOutput("seq3_retired_end", Retired, 32'd4);
      checkOutput("seq3_mem40", mem[16], 32'd12);
      checkOutput("seq3_q_empty", exp_q.size(), 32'd0);

      // Table of ALU operations, each run as a small program.
      for (int v = 0; v < 10; v++) begin
         begin_test();
         mem[0] = enc_i(6'h08, 5'd0, 5'd1, vecs[v].imm_a);
         mem[1] = enc_i(6'h08, 5'd0, 5'd2, vecs[v].imm_b);
         mem[2] = enc_r(5'd1, 5'd2, 5'd3, vecs[v].funct);
         mem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
         mem[4] = HALT_WORD;
         exp_q.push_back('{32'h40, vecs[v].expected});
         applyStimulus(vecs[v].waits);
         wait_for_halt(200, cyc);
         checkOutput({vecs[v].name, "_cycles"}, cyc, 18 + 6 * vecs[v].waits);
         checkOutput({vecs[v].name, "_retired"}, Retired, 32'd4);
         checkOutput({vecs[v].name, "_memreq"}, {31'd0, MemReq}, 32'd0);
         checkOutput({vecs[v].name, "_q_empty"}, exp_q.size(), 32'd0);
      end

      // sw then lw with three wait states per access.
      begin_test();
      mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
      mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
      mem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
      mem[3] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0044);
      mem[4] = HALT_WORD;
      exp_q.push_back('{32'h40, 32'd12});
      exp_q.push_back('{32'h44, 32'd12});
      applyStimulus(3);
      wait_for_halt(200, cyc);
      checkOutput("lwsw_cycles", cyc, 32'd43);
      checkOutput("lwsw_retired", Retired, 32'd4);
      checkOutput("lwsw_mem40", mem[16], 32'd12);
      checkOutput("lwsw_mem44", mem[17], 32'd12);
      checkOutput("lwsw_q_empty", exp_q.size(), 32'd0);

      // beq not taken, then beq to itself.
      begin_test();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
      mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd4);
      mem[2] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
      mem[3] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
      applyStimulus(0);
      step(8);
      checkOutput("beq_pre_pc", PC, BASE + 32'd8);
      step(3);
      checkOutput("beq_nt_pc", PC, BASE + 32'd12);
      checkOutput("beq_nt_retired", Retired, 32'd3);
      step(1);
      checkOutput("beq_fetch_pc", PC, BASE + 32'd16);
      step(2);
      checkOutput("beq_self_pc", PC, BASE + 32'd12);
      checkOutput("beq_self_retired", Retired, 32'd4);
      step(3);
      checkOutput("beq_self2_pc", PC, BASE + 32'd12);
      checkOutput("beq_self2_retired", Retired, 32'd5);

      // Jump within the current 256 MB segment.
      begin_test();
      mem[0]   = {6'h02, 26'h000_0100};
      mem[256] = HALT_WORD;
      applyStimulus(0);
      step(3);
      checkOutput("j_pc", PC, 32'h1000_0400);
      checkOutput("j_retired", Retired, 32'd1);
      wait_for_halt(20, cyc);
      checkOutput("j_halt_retired", Retired, 32'd1);

      // Unsupported opcode halts after DECODE and stays halted.
      begin_test();
      mem[0] = HALT_WORD;
      applyStimulus(0);
      step(1);
      checkOutput("halt_decode", {31'd0, Halted}, 32'd0);
      step(1);
      checkOutput("halt_set", {31'd0, Halted}, 32'd1);
      checkOutput("halt_memreq", {31'd0, MemReq}, 32'd0);
      checkOutput("halt_retired", Retired, 32'd0);
      step(10);
      checkOutput("halt_hold", {31'd0, Halted}, 32'd1);
      checkOutput("halt_hold_memreq", {31'd0, MemReq}, 32'd0);
      checkOutput("halt_hold_pc", PC, BASE + 32'd4);
      checkOutput("halt_hold_retired", Retired, 32'd0);

      // Unsupported R-type funct (all-zero word) also halts.
      begin_test();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
      applyStimulus(0);
      wait_for_halt(30, cyc);
      checkOutput("funct0_cycles", cyc, 32'd6);
      checkOutput("funct0_retired", Retired, 32'd1);

      // bne with $1 != $2.
      begin_test();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
      mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
      mem[2] = enc_i(6'h05, 5'd1, 5'd2, 16'd2);
      mem[3] = HALT_WORD;
      mem[4] = HALT_WORD;
      mem[5] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0040);
      mem[6] = HALT_WORD;
`ifdef MIPS_MC_BNE_EN
      exp_q.push_back('{32'h40, 32'd1});
      applyStimulus(0);
      step(11);
      checkOutput("bne_pc", PC, BASE + 32'd20);
      checkOutput("bne_retired", Retired, 32'd3);
      wait_for_halt(30, cyc);
      checkOutput("bne_end_retired", Retired, 32'd4);
      checkOutput("bne_q_empty", exp_q.size(), 32'd0);
`else
      applyStimulus(0);
      step(10);
      checkOutput("bne_off_halted", {31'd0, Halted}, 32'd1);
      checkOutput("bne_off_retired", Retired, 32'd2);
      checkOutput("bne_off_pc", PC, BASE + 32'd12);
      checkOutput("bne_off_memreq", {31'd0, MemReq}, 32'd0);
`endif

      // RESET pulsed while a load waits in MEMRD.
      begin_test();
      mem[0]  = enc_i(6'h08, 5'd0, 5'd5, 16'd9);
      mem[1]  = enc_i(6'h23, 5'd0, 5'd5, 16'h0040);
      mem[16] = 32'h0000_0055;
      applyStimulus(3);
      step(14);
      checkOutput("rmid_memreq", {31'd0, MemReq}, 32'd1);
      checkOutput("rmid_memaddr", MemAddr, 32'h0000_0040);
      checkOutput("rmid_memwe", {31'd0, MemWE}, 32'd0);
      checkOutput("rmid_retired", Retired, 32'd1);
      RESET = 1'b1;
      #1;
      checkOutput("rmid_req_drop", {31'd0, MemReq}, 32'd0);
      checkOutput("rmid_addr_drop", MemAddr, 32'd0);
      step(1);
      checkOutput("rmid_post_memreq", {31'd0, MemReq}, 32'd0);
      checkOutput("rmid_post_pc", PC, BASE);
      checkOutput("rmid_post_retired", Retired, 32'd0);
      checkOutput("rmid_post_halted", {31'd0, Halted}, 32'd0);
      RESET = 1'b0;
      #1;
      checkOutput("rmid_restart_req", {31'd0, MemReq}, 32'd1);
      checkOutput("rmid_restart_addr", MemAddr, BASE);

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
